// File: rtl/dmux8_burst_scheduler_if.sv
// Bundle for dmux8_burst_scheduler: one producer stream plus eight sink lanes.
// "master" is the scheduler's view, "slave" is the producer/sink environment's view.
interface dmux8_burst_scheduler_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] X;
  logic             X_VALID;
  logic             X_LAST;
  logic             X_READY;
  logic [WIDTH-1:0] OUT1;
  logic [WIDTH-1:0] OUT2;
  logic [WIDTH-1:0] OUT3;
  logic [WIDTH-1:0] OUT4;
  logic [WIDTH-1:0] OUT5;
  logic [WIDTH-1:0] OUT6;
  logic [WIDTH-1:0] OUT7;
  logic [WIDTH-1:0] OUT8;
  logic [7:0]       OUT_VALID;
  logic [7:0]       OUT_READY;
  logic [2:0]       s;
  logic             BUSY;

  modport master (
    input  X, X_VALID, X_LAST, OUT_READY,
    output X_READY, OUT1, OUT2, OUT3, OUT4, OUT5, OUT6, OUT7, OUT8,
    output OUT_VALID, s, BUSY
  );

  modport slave (
    output X, X_VALID, X_LAST, OUT_READY,
    input  X_READY, OUT1, OUT2, OUT3, OUT4, OUT5, OUT6, OUT7, OUT8,
    input  OUT_VALID, s, BUSY
  );
endinterface

// File: rtl/dmux8_burst_scheduler.sv
// Burst scheduler steering one valid/ready source onto 8 sinks through an external DMUX8Way.
// Optional macro DMUX8_SCHED_FIXED_PRIO_EN: grant search always starts at OUT1 (fixed priority).
//
// Handshake: a beat moves on a cycle where X_VALID && X_READY; X_READY is only
// ever high in LOCKED and then mirrors the selected sink's OUT_READY, so source
// and sink see the same transfer in the same cycle.
module dmux8_burst_scheduler #(
  parameter int WIDTH   = 1,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  dmux8_burst_scheduler_if.master bus,
  output logic                    o_dbg_state
);
  localparam int BW = $clog2(BURST + 1);
  localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t          r_state;
  logic [2:0]      r_s;
  logic [2:0]      r_ptr;
  logic [BW-1:0]   r_beat_cnt;
  logic [SW-1:0]   r_stall_cnt;

  state_t          w_state_nxt;
  logic [2:0]      w_s_nxt;
  logic [2:0]      w_ptr_nxt;
  logic [BW-1:0]   w_beat_nxt;
  logic [SW-1:0]   w_stall_nxt;
  logic [2:0]      w_start;
  logic [2:0]      w_grant;
  logic            w_found;
  logic            w_xfer;
  logic            w_release;
  logic            w_x_ready;
  logic            w_busy;
  logic [7:0]      w_out_valid;
  logic [WIDTH-1:0] w_out [8];

`ifdef DMUX8_SCHED_FIXED_PRIO_EN
  assign w_start = 3'd0;
`else
  assign w_start = r_ptr;
`endif

  // Descending scan so the smallest offset from w_start wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = w_start;
    for (int k = 7; k >= 0; k--) begin
      if (bus.OUT_READY[w_start + 3'(k)]) begin
        w_found = 1'b1;
        w_grant = w_start + 3'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_s         <= 3'd0;
      r_ptr       <= 3'd0;
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_s         <= w_s_nxt;
      r_ptr       <= w_ptr_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_stall_cnt <= w_stall_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_ptr_nxt   = r_ptr;
    w_beat_nxt  = r_beat_cnt;
    w_stall_nxt = r_stall_cnt;
    w_xfer      = 1'b0;
    w_release   = 1'b0;
    w_x_ready   = 1'b0;
    w_busy      = 1'b0;
    w_out_valid = 8'd0;
    for (int n = 0; n < 8; n++) w_out[n] = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.X_VALID && w_found) begin
          w_state_nxt = ST_LOCKED;
          w_s_nxt     = w_grant;
          w_beat_nxt  = '0;
          w_stall_nxt = '0;
        end
      end
      ST_LOCKED: begin
        w_busy             = 1'b1;
        w_x_ready          = bus.OUT_READY[r_s];
        w_out_valid[r_s]   = bus.X_VALID;
        w_out[r_s]         = bus.X;
        w_xfer             = bus.X_VALID & bus.OUT_READY[r_s];
        if (w_xfer) begin
          w_stall_nxt = '0;
          if (bus.X_LAST || (r_beat_cnt == BW'(BURST - 1))) w_release = 1'b1;
          else w_beat_nxt = r_beat_cnt + 1'b1;
        end else begin
          if (r_stall_cnt != '1) w_stall_nxt = r_stall_cnt + 1'b1;
          // A stalled beat is left at the source; only the grant is dropped.
          if ((TIMEOUT != 0) && (r_stall_cnt == SW'(TIMEOUT - 1))) w_release = 1'b1;
        end
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_beat_nxt  = '0;
          w_stall_nxt = '0;
`ifndef DMUX8_SCHED_FIXED_PRIO_EN
          w_ptr_nxt   = r_s + 3'd1;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.X_READY   = w_x_ready;
  assign bus.OUT_VALID = w_out_valid;
  assign bus.s         = r_s;
  assign bus.BUSY      = w_busy;
  assign bus.OUT1      = w_out[0];
  assign bus.OUT2      = w_out[1];
  assign bus.OUT3      = w_out[2];
  assign bus.OUT4      = w_out[3];
  assign bus.OUT5      = w_out[4];
  assign bus.OUT6      = w_out[5];
  assign bus.OUT7      = w_out[6];
  assign bus.OUT8      = w_out[7];
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_dmux8_burst_scheduler.sv
// Directed bench for dmux8_burst_scheduler: grant-level reference model plus literal spot checks.
module tb_dmux8_burst_scheduler;
  localparam int WIDTH   = 4;
  localparam int BURST   = 4;
  localparam int TIMEOUT = 8;
`ifdef DMUX8_SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk;
  logic reset_n;
  logic dbg_state;
  int   checks;
  int   errors;

  dmux8_burst_scheduler_if #(.WIDTH(WIDTH)) bus ();

  dmux8_burst_scheduler #(.WIDTH(WIDTH), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the grant, how many beats/stall cycles it has seen.
  logic       m_live;
  logic       m_busy;
  logic [2:0] m_sel;
  logic [2:0] m_ptr;
  int         m_beats;
  int         m_stalls;

  function automatic logic [2:0] pick(input logic [2:0] start, input logic [7:0] rdy);
    int q[$];
    for (int k = 0; k < 8; k++) q.push_back((int'(start) + k) % 8);
    while (q.size() > 0 && !rdy[q[0]]) void'(q.pop_front());
    return (q.size() > 0) ? 3'(q[0]) : 3'd0;
  endfunction

  initial m_live = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_live <= 1'b1; m_busy <= 1'b0; m_sel <= 3'd0; m_ptr <= 3'd0;
      m_beats <= 0; m_stalls <= 0;
    end else if (!m_busy) begin
      if (bus.X_VALID && bus.OUT_READY != 8'd0) begin
        m_busy <= 1'b1; m_beats <= 0; m_stalls <= 0;
        m_sel  <= pick(FIXED ? 3'd0 : m_ptr, bus.OUT_READY);
      end
    end else if (bus.X_VALID && bus.OUT_READY[m_sel]) begin
      m_beats <= m_beats + 1; m_stalls <= 0;
      if (bus.X_LAST || m_beats + 1 == BURST) begin
        m_busy <= 1'b0;
        if (!FIXED) m_ptr <= m_sel + 3'd1;
      end
    end else begin
      m_stalls <= m_stalls + 1;
      if (TIMEOUT != 0 && m_stalls + 1 == TIMEOUT) begin
        m_busy <= 1'b0;
        if (!FIXED) m_ptr <= m_sel + 3'd1;
      end
    end
  end

  // Scoreboard: every cycle after the first reset edge, compare all outputs.
  logic [31:0] exp_outs;
  logic [7:0]  exp_valid;
  always @(negedge clk) begin
    if (m_live) begin
      exp_outs  = m_busy ? (32'(bus.X) << (WIDTH * int'(m_sel))) : 32'd0;
      exp_valid = (m_busy && bus.X_VALID) ? (8'd1 << m_sel) : 8'd0;
      check("s", 32'(bus.s), 32'(m_sel));
      check("busy", 32'(bus.BUSY), 32'(m_busy));
      check("dbg_state", 32'(dbg_state), 32'(m_busy));
      check("x_ready", 32'(bus.X_READY), 32'(m_busy & bus.OUT_READY[m_sel]));
      check("out_valid", 32'(bus.OUT_VALID), 32'(exp_valid));
      check("out_data", {bus.OUT8, bus.OUT7, bus.OUT6, bus.OUT5,
                         bus.OUT4, bus.OUT3, bus.OUT2, bus.OUT1}, exp_outs);
      check("onehot", 32'($countones(bus.OUT_VALID) <= 1), 32'd1);
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.X = bus.X + 1'b1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; bus.X_VALID = 1'b0; bus.X_LAST = 1'b0; bus.OUT_READY = 8'd0;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.X = '0;
    do_reset();

    // Reset then idle
    tick(3);
    check("idle_s", 32'(bus.s), 32'd0);
    check("idle_busy", 32'(bus.BUSY), 32'd0);
    check("idle_valid", 32'(bus.OUT_VALID), 32'd0);

    // Full bursts across all sinks, one idle cycle between grants
    bus.OUT_READY = 8'hFF; bus.X_VALID = 1'b1;
    tick(1);
    for (int g = 0; g < 8; g++) begin
      check("burst_s", 32'(bus.s), FIXED ? 32'd0 : 32'(g));
      check("burst_xready", 32'(bus.X_READY), 32'd1);
      tick(4);
      check("burst_gap", 32'(bus.BUSY), 32'd0);
      tick(1);
    end
    check("burst_wrap", 32'(bus.s), 32'd0);

    // Round-robin skip over non-ready sinks
    do_reset();
    bus.OUT_READY = 8'b0010_0100; bus.X_VALID = 1'b1;
    tick(1);
    check("rr_first", 32'(bus.s), 32'd2);
    tick(5);
    check("rr_second", 32'(bus.s), FIXED ? 32'd2 : 32'd5);
    tick(5);
    check("rr_third", 32'(bus.s), 32'd2);

    // Early end on X_LAST at the second beat
    do_reset();
    bus.OUT_READY = 8'hFF; bus.X_VALID = 1'b1;
    tick(1);
    check("last_grant", 32'(bus.s), 32'd0);
    tick(1);
    bus.X_LAST = 1'b1;
    tick(1);
    bus.X_LAST = 1'b0;
    check("last_release", 32'(bus.BUSY), 32'd0);
    tick(1);
    check("last_next", 32'(bus.s), FIXED ? 32'd0 : 32'd1);

    // Timeout with the granted sink stalled; other ready sinks are ignored
    do_reset();
    bus.OUT_READY = 8'b0000_1000; bus.X_VALID = 1'b1;
    tick(1);
    check("to_grant", 32'(bus.s), 32'd3);
    bus.OUT_READY = 8'b1111_0111;
    tick(7);
    check("to_still_busy", 32'(bus.BUSY), 32'd1);
    check("to_no_ready", 32'(bus.X_READY), 32'd0);
    tick(1);
    check("to_released", 32'(bus.BUSY), 32'd0);
    tick(1);
    check("to_ptr", 32'(bus.s), FIXED ? 32'd0 : 32'd4);

    // Reset during the second beat of a burst
    do_reset();
    bus.OUT_READY = 8'hFF; bus.X_VALID = 1'b1;
    tick(2);
    check("mid_busy", 32'(bus.BUSY), 32'd1);
    reset_n = 1'b0;
    tick(1);
    check("mid_rst_busy", 32'(bus.BUSY), 32'd0);
    check("mid_rst_valid", 32'(bus.OUT_VALID), 32'd0);
    check("mid_rst_xready", 32'(bus.X_READY), 32'd0);
    check("mid_rst_s", 32'(bus.s), 32'd0);
    reset_n = 1'b1;
    tick(1);
    check("mid_regrant", 32'(bus.s), 32'd0);
    tick(3);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmux8_burst_scheduler.md
Name: dmux8_burst_scheduler

Overview:
- Sequences an external DMUX8Way: shares one source stream among 8 sinks, round-robin over the sinks that are ready.
- Drives the 3-bit select `s`. Gates the data onto the chosen OUTn. Holds a grant for a burst of beats.
- Sits between a single producer (valid/ready) and eight consumers (valid/ready each).

Parameters:
- WIDTH, 1, data bits per beat on X and on each OUTn
- BURST, 4, maximum beats per grant (1..255)
- TIMEOUT, 8, consecutive no-transfer cycles in LOCKED before the grant is released (0 = never release)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- X  in  WIDTH  source data
- X_VALID  in  1  source beat valid
- X_LAST  in  1  beat is last of its packet; qualified by X_VALID
- X_READY  out  1  scheduler accepts beat this cycle
- OUT1..OUT8  out  WIDTH each  sink data (X on the selected sink, 0 on all others)
- OUT_VALID  out  8  one-hot sink valid; bit n-1 belongs to OUTn
- OUT_READY  in  8  sink ready; bit n-1 belongs to OUTn
- s  out  3  current select (0 selects OUT1); feeds the external DMUX8Way
- BUSY  out  1  high while in LOCKED

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: state=IDLE, ptr=0, s=0, beat_cnt=0, stall_cnt=0, BUSY=0, X_READY=0, OUT_VALID=0, OUT1..OUT8=0.
- Registered state: state {IDLE, LOCKED}, s[2:0], ptr[2:0], beat_cnt, stall_cnt. All outputs derive combinationally from these registers plus inputs.
- IDLE:
  - Outputs: X_READY=0, OUT_VALID=0, all OUTn=0. s holds its previous value.
  - When X_VALID=1 and OUT_READY!=0: grant = first index i with OUT_READY[i]=1, searching ptr, ptr+1, ... mod 8 (wrap 7->0).
  - Next cycle: s<=grant, state<=LOCKED, beat_cnt<=0, stall_cnt<=0.
  - Arbitration latency is exactly 1 cycle. No beat transfers in IDLE.
  - When X_VALID=0 or OUT_READY=0: remain in IDLE.
- LOCKED:
  - Outputs: X_READY=OUT_READY[s]; OUT_VALID[s]=X_VALID, all other bits 0; OUT(s+1)=X, all other OUTn=0; BUSY=1.
  - Transfer: X_VALID & X_READY.
  - Data path is a zero-latency pass-through.
- Per transfer:
  - beat_cnt increments and stall_cnt clears.
  - Release when the transfer has X_LAST=1, or when beat_cnt==BURST-1.
  - On release: state<=IDLE, ptr<=s+1 mod 8, beat_cnt<=0.
- Per cycle in LOCKED without a transfer (X_VALID=0, or the selected sink is not ready):
  - stall_cnt increments and saturates.
  - If TIMEOUT!=0 and stall_cnt reaches TIMEOUT-1: release, ptr<=s+1. The held beat stays at the source.
- Simultaneous events:
  - X_LAST on beat BURST-1: single release.
  - Timeout cannot coincide with a transfer.
  - OUT_READY of other sinks is ignored while LOCKED.
- Reset mid-burst: next cycle returns to reset values. The partial burst is abandoned, with no further OUT_VALID.
- Width rules:
  - beat_cnt is clog2(BURST+1) bits; stall_cnt is clog2(TIMEOUT+1) bits (min 1).
  - ptr and s wrap modulo 8.
- Invariant: OUT_VALID is always one-hot or zero.

Optional Feature:
- Macro: DMUX8_SCHED_FIXED_PRIO_EN.
- Defined: the grant search always starts at index 0, giving fixed priority (OUT1 highest). ptr stays 0 and is never updated.
- Undefined (default): round-robin from ptr as described in Behaviour.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, release, X_VALID=0 -> OUT_VALID=0, X_READY=0, s=0, BUSY=0 throughout.
- Full burst: BURST=4, OUT_READY=8'hFF, X_VALID=1 continuously, X=1 -> 1 idle cycle, then 4 beats on OUT1 (s=0), 1 idle cycle, then 4 beats on OUT2 (s=1). Continue through s=7 -> wraps to s=0.
- Round-robin skip: OUT_READY=8'b0010_0100, ptr=0 -> grant s=2; after release -> s=5; next grant -> s=2.
- Early end: X_LAST=1 on the 2nd beat -> release after 2 beats; next grant starts at s+1.
- Timeout: TIMEOUT=8, grant s=3, then OUT_READY[3]=0 with X_VALID=1 -> 8 stall cycles, IDLE, ptr=4, no beat lost (X_READY never asserted).
- Reset mid-burst plus fixed priority: reset_n=0 during beat 2 -> next cycle all outputs at reset values. With DMUX8_SCHED_FIXED_PRIO_EN and OUT_READY=8'hFF -> every grant is s=0.
